// File: rtl/imem_loader.sv
// imem_loader
//
// Writer side of the MIPS16 instruction memory. Accepts a program image as a
// byte stream (count byte N, 2N data bytes high-byte first, XOR checksum),
// assembles 16-bit instruction words and drives a registered write port into
// the instruction store. The CPU is held stalled until a complete image with
// a matching checksum is resident.
//
// Ports:
//   clk        : system clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle load request, honoured in IDLE, DONE and ERR only
//   byte_in    : stream byte
//   byte_valid : byte_in is valid
//   byte_ready : loader accepts a byte this cycle (decode of state only)
//   wr_en      : instruction store write strobe, one cycle per word
//   wr_addr    : word address of the write
//   wr_data    : instruction word of the write
//   cpu_hold   : stalls the PC / holds the CPU in reset while 1
//   done       : image loaded and verified (level)
//   error      : load failed (level)

module imem_loader #(
  parameter int WORDS  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] WORDS_B = 8'(WORDS);

  state_t              state_reg;
  // One bit wider than the address so that N = WORDS is representable.
  logic [ADDR_W:0]     idx_reg;
  logic [ADDR_W:0]     n_reg;
  logic [7:0]          csum_reg;
  logic [7:0]          hi_reg;
  logic                wr_en_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [DATA_W-1:0]   wr_data_reg;
  logic                cpu_hold_reg;
  logic                done_reg;
  logic                error_reg;
  logic                accept;

  // Ready depends only on the state register, never on byte_valid.
  assign byte_ready = (state_reg == S_COUNT) || (state_reg == S_HI) ||
                      (state_reg == S_LO)    || (state_reg == S_CHECK);
  assign accept     = byte_ready && byte_valid;

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign cpu_hold = cpu_hold_reg;
  assign done     = done_reg;
  assign error    = error_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      n_reg        <= '0;
      csum_reg     <= '0;
      hi_reg       <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      cpu_hold_reg <= 1'b1;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold otherwise.
      wr_en_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_reg    <= S_COUNT;
            idx_reg      <= '0;
            csum_reg     <= '0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            cpu_hold_reg <= 1'b1;
          end
        end
        S_COUNT: begin
          if (accept) begin
            if ((byte_in == 8'd0) || (byte_in > WORDS_B)) begin
              state_reg <= S_ERR;
              error_reg <= 1'b1;
            end else begin
              n_reg     <= byte_in[ADDR_W:0];
              state_reg <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            hi_reg    <= byte_in;
            csum_reg  <= csum_reg ^ byte_in;
            state_reg <= S_LO;
          end
        end
        S_LO: begin
          if (accept) begin
            csum_reg    <= csum_reg ^ byte_in;
            wr_en_reg   <= 1'b1;
            wr_addr_reg <= idx_reg[ADDR_W-1:0];
            wr_data_reg <= DATA_W'({hi_reg, byte_in});
            idx_reg     <= idx_reg + 1'b1;
            // Compare against the pre-increment index.
            if (idx_reg == n_reg - 1'b1) begin
              state_reg <= S_CHECK;
            end else begin
              state_reg <= S_HI;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (byte_in == csum_reg) begin
              state_reg    <= S_DONE;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
            end else begin
              state_reg <= S_ERR;
              error_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Expected writes are pushed to a scoreboard
// queue as the image is streamed and popped by a monitor on every wr_en pulse.

module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [19:0] exp_q[$];
  logic [15:0] img[16];

  imem_loader #(.WORDS(16), .DATA_W(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h required %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    logic [19:0] e;
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {12'h0, wr_addr, wr_data}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("write", {12'h0, wr_addr, wr_data}, {12'h0, e});
        $display("write addr=%0d data=%04h expected addr=%0d data=%04h",
                 wr_addr, wr_data, e[19:16], e[15:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    if (gap) begin
      @(negedge clk);
    end
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      check("ready_timeout", {31'h0, byte_ready}, 32'h1);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", {31'h0, byte_ready}, 32'h1);
    check("hold_after_start", {31'h0, cpu_hold}, 32'h1);
  endtask

  task automatic send_image(input int n, input logic [7:0] csum_flip, input bit gap);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({4'(i), img[i]});
      send_byte(img[i][15:8], gap);
      send_byte(img[i][7:0], gap);
      cs = cs ^ img[i][15:8] ^ img[i][7:0];
    end
    send_byte(cs ^ csum_flip, gap);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    @(negedge clk);
    check({tag, "_done"}, {31'h0, done}, {31'h0, d});
    check({tag, "_error"}, {31'h0, error}, {31'h0, e});
    check({tag, "_hold"}, {31'h0, cpu_hold}, {31'h0, h});
    check({tag, "_sb_empty"}, exp_q.size(), 32'h0);
    $display("%s: done=%0b error=%0b cpu_hold=%0b", tag, done, error, cpu_hold);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, byte_ready}, 32'h0);
    check("rst_wr_en", {31'h0, wr_en}, 32'h0);
    check("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
    check("rst_wr_data", {16'h0, wr_data}, 32'h0);
    check("rst_hold", {31'h0, cpu_hold}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'h0, byte_ready}, 32'h0);

    // Nominal load: 02 12 34 AB CD 40.
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    pulse_start();
    send_image(2, 8'h00, 1'b0);
    check_status("nominal", 1'b1, 1'b0, 1'b0);

    // Full 16-word image with byte_valid gaps.
    for (int i = 0; i < 16; i++) img[i] = 16'(i);
    pulse_start();
    send_image(16, 8'h00, 1'b1);
    check_status("full_gaps", 1'b1, 1'b0, 1'b0);
    check("full_last_addr", {28'h0, wr_addr}, 32'hF);

    // Bad counts 00 and 11 go straight to ERR with no writes.
    pulse_start();
    send_byte(8'h00, 1'b0);
    check_status("count_00", 1'b0, 1'b1, 1'b1);
    pulse_start();
    check("restart_clears_error", {31'h0, error}, 32'h0);
    send_byte(8'h11, 1'b0);
    check_status("count_11", 1'b0, 1'b1, 1'b1);

    // Checksum mismatch still writes both words, then recovery.
    img[0] = 16'h1234;
    img[1] = 16'hABCD;
    pulse_start();
    send_image(2, 8'h01, 1'b0);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1);
    pulse_start();
    send_image(2, 8'h00, 1'b0);
    check_status("recover", 1'b1, 1'b0, 1'b0);

    // Reset after the HI byte of word 1: no write for word 1.
    pulse_start();
    send_byte(8'h02, 1'b0);
    exp_q.push_back({4'd0, 16'h1234});
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'h0, byte_ready}, 32'h0);
    check("midrst_wr_en", {31'h0, wr_en}, 32'h0);
    check("midrst_wr_addr", {28'h0, wr_addr}, 32'h0);
    check("midrst_wr_data", {16'h0, wr_data}, 32'h0);
    check("midrst_hold", {31'h0, cpu_hold}, 32'h1);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_error", {31'h0, error}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_sb_empty", exp_q.size(), 32'h0);
    img[0] = 16'h5A5A;
    img[1] = 16'hC3C3;
    pulse_start();
    send_image(2, 8'h00, 1'b0);
    check_status("after_reset", 1'b1, 1'b0, 1'b0);

    // start pulsed while in LO is ignored.
    img[0] = 16'h0F0F;
    img[1] = 16'h7001;
    pulse_start();
    send_byte(8'h02, 1'b0);
    exp_q.push_back({4'd0, img[0]});
    exp_q.push_back({4'd1, img[1]});
    send_byte(img[0][15:8], 1'b0);
    start = 1'b1;
    send_byte(img[0][7:0], 1'b0);
    start = 1'b0;
    send_byte(img[1][15:8], 1'b0);
    send_byte(img[1][7:0], 1'b0);
    send_byte(img[0][15:8] ^ img[0][7:0] ^ img[1][15:8] ^ img[1][7:0], 1'b0);
    check_status("start_in_lo", 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
